decoded_byte_rx_buffer: RTL
===========================

Name: decoded_byte_rx_buffer

Overview:
- Receive-side stage directly downstream of the Hamming encoder/medium/decoder chain.
- Samples the decoded byte and its `error` flag on a strobe and buffers {error, byte} in a FIFO toward a valid/ready consumer.
- Keeps saturating byte and error statistics.
- Runs a burst-error alarm FSM that flags a degraded noisy channel.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the statistics counters.
- BURST_N, 3, consecutive errored samples that raise the alarm.
- CLEAN_N, 8, consecutive clean samples that clear the alarm.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- sample_en  input  1  qualifies data_in/error_in this cycle as one received byte.
- data_in  input  8  decoded byte from the decoder pair.
- error_in  input  1  OR of the two decoder error flags for this byte.
- clear_stats  input  1  synchronous clear of counters, overflow and alarm.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer accepts the head when high together with out_valid.
- out_data  output  8  head byte.
- out_err  output  1  error flag stored with the head byte.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- byte_count  output  CNT_W  sampled bytes, including dropped ones; saturating.
- err_count  output  CNT_W  sampled bytes with error_in=1; saturating.
- overflow  output  1  sticky flag: a byte was dropped because the FIFO was full.
- alarm  output  1  burst-error alarm.

Behaviour:
- Reset (asynchronous, active-high):
  - FIFO empty, pointers 0, level=0.
  - out_valid=0, out_data=0, out_err=0.
  - Both counters 0, overflow=0.
  - FSM in CLEAR, run counter 0, alarm=0.
  - Reset mid-operation discards all FIFO contents immediately.
- Push: sample_en=1 writes {error_in, data_in} at the write pointer if a slot is free.
- Pop: out_valid and out_ready both high advances the read pointer.
- Latency: a byte pushed into an empty FIFO at edge N appears with out_valid=1 after edge N. No combinational path from data_in to out_data.
- out_data and out_err come from the head entry; they hold stable while out_valid=1 and out_ready=0.
- Full, with push and pop in the same cycle: push is accepted; level stays DEPTH.
- Full, push without pop: byte dropped; overflow set; byte_count and err_count still count it.
- Empty, push in the same cycle: no pop possible (out_valid=0); level goes to 1.
- Non-full, simultaneous push and pop: level unchanged.
- Pointers wrap modulo DEPTH; full and empty are distinguished by the level counter.
- level changes by at most 1 per cycle.
- Counters:
  - byte_count increments on every sample_en.
  - err_count increments on sample_en with error_in=1.
  - Both saturate at 2^CNT_W-1.
- clear_stats:
  - Counters, overflow and the FSM return to their reset values first.
  - A sample in the same cycle is then counted, so the counters read 0 or 1 after that edge.
  - The FIFO is unaffected.
- Alarm FSM, which advances only on sample_en cycles:
  - CLEAR, alarm=0.
    - Errored sample: run+1. Clean sample: run=0.
    - When run reaches BURST_N-1 and the sample is errored: go to ALARM, run=0.
  - ALARM, alarm=1.
    - Clean sample: run+1. Errored sample: run=0.
    - When run reaches CLEAN_N-1 and the sample is clean: go to CLEAR, run=0.
  - The alarm output is registered and changes on the edge that samples the triggering byte.
- clear_stats forces the FSM to CLEAR with run=0; a sample in the same cycle is then applied from CLEAR.

Test Plan:
- Stream with out_ready held at 1: reset, then 5 samples 0x11,0x22,0x33,0x44,0x55 with error_in=0 → bytes emerge in order, each one cycle after its sample; level ≤1; byte_count=5, err_count=0, alarm=0.
- Fill and overflow: out_ready=0, 18 samples 0x00..0x11 → level=16, overflow=1, byte_count=18; draining yields exactly 0x00..0x0F.
- Full with simultaneous push and pop: FIFO full, sample 0xA5 with out_ready=1 → 0xA5 accepted, level stays 16, overflow unchanged; 0xA5 is the last byte drained.
- Burst alarm: error pattern 1,1,0,1,1,1 → alarm rises only after the 6th sample; then 7 clean samples keep alarm=1 and the 8th clears it; err_count=5.
- clear_stats: clear_stats asserted with a same-cycle errored sample → byte_count=1, err_count=1, overflow=0, alarm=0, FIFO contents intact.
- Reset mid-stream: assert reset asynchronously with level=7 and alarm=1 → out_valid, level, counters and alarm go to 0 before the next edge; normal operation resumes after reset is released.

Source files
------------

// File: rtl/decoded_byte_rx_buffer.sv
// Receive buffer behind the Hamming decoder: FIFOs {error, byte} samples toward a
// valid/ready consumer, keeps saturating statistics and raises a burst-error alarm.
module decoded_byte_rx_buffer #(
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 16,
  parameter int BURST_N = 3,
  parameter int CLEAN_N = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_en,
  input  logic [7:0]               data_in,
  input  logic                     error_in,
  input  logic                     clear_stats,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         byte_count,
  output logic [CNT_W-1:0]         err_count,
  output logic                     overflow,
  output logic                     alarm
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int RUN_W = $clog2(BURST_N + CLEAN_N) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {ST_CLEAR, ST_ALARM} state_t;

  logic [8:0]       mem_q [DEPTH];
  logic [8:0]       mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             overflow_q, overflow_d;
  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             alarm_q, alarm_d;

  logic full, empty, push, pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign pop   = !empty && out_ready;
  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  assign push  = sample_en && (!full || pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = {error_in, data_in};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
  end

  // clear_stats zeroes first, then a same-cycle sample is counted on top.
  always_comb begin
    byte_cnt_d = clear_stats ? '0 : byte_cnt_q;
    err_cnt_d  = clear_stats ? '0 : err_cnt_q;
    overflow_d = clear_stats ? 1'b0 : overflow_q;
    if (sample_en) begin
      if (byte_cnt_d != CNT_MAX) byte_cnt_d = byte_cnt_d + 1'b1;
      if (error_in && err_cnt_d != CNT_MAX) err_cnt_d = err_cnt_d + 1'b1;
      if (full && !pop) overflow_d = 1'b1;
    end
  end

  always_comb begin
    state_d = clear_stats ? ST_CLEAR : state_q;
    run_d   = clear_stats ? '0 : run_q;
    if (sample_en) begin
      case (state_d)
        ST_CLEAR: begin
          if (!error_in) begin
            run_d = '0;
          end else if (run_d == RUN_W'(BURST_N - 1)) begin
            state_d = ST_ALARM;
            run_d   = '0;
          end else begin
            run_d = run_d + 1'b1;
          end
        end
        default: begin
          if (error_in) begin
            run_d = '0;
          end else if (run_d == RUN_W'(CLEAN_N - 1)) begin
            state_d = ST_CLEAR;
            run_d   = '0;
          end else begin
            run_d = run_d + 1'b1;
          end
        end
      endcase
    end
    alarm_d = (state_d == ST_ALARM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      byte_cnt_q <= '0;
      err_cnt_q  <= '0;
      overflow_q <= 1'b0;
      state_q    <= ST_CLEAR;
      run_q      <= '0;
      alarm_q    <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      byte_cnt_q <= byte_cnt_d;
      err_cnt_q  <= err_cnt_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      run_q      <= run_d;
      alarm_q    <= alarm_d;
    end
  end

  assign out_valid  = !empty;
  assign out_data   = empty ? 8'h00 : mem_q[rd_ptr_q][7:0];
  assign out_err    = empty ? 1'b0 : mem_q[rd_ptr_q][8];
  assign level      = level_q;
  assign byte_count = byte_cnt_q;
  assign err_count  = err_cnt_q;
  assign overflow   = overflow_q;
  assign alarm      = alarm_q;

endmodule
